i2c_slave_target: RTL and testbench
===================================

// Module: i2c_slave_target
// PURPOSE
//   Native I2C target (slave) on the FPGA fabric, clocked from PCLK; the responder end of the
//   bus our CoreI2C masters drive. Decodes START/STOP, matches a 7-bit address, keeps an 8-bit
//   register pointer and moves bytes to/from an external register bank. Open-drain SDA only;
//   never stretches SCL.
// PARAMETERS
//   SLAVE_ADDR  7'h3C  7-bit bus address answered
//   FILT_LEN    3      cycles a synchronized line must be stable before the filtered value updates
// PORTS
//   PCLK         in   1  system clock (PCLK >= 20x SCL)
//   PRESETN      in   1  asynchronous active-low reset
//   SCL_IN       in   1  SCL pad input
//   SDA_IN       in   1  SDA pad input
//   SDA_OE       out  1  1 = pull SDA low; 0 = release (pad logic ties output data to 0)
//   reg_wr_en    out  1  one-cycle write strobe
//   reg_addr     out  8  register pointer: write address when reg_wr_en=1, else read address
//   reg_wr_data  out  8  write data, valid with reg_wr_en
//   reg_rd_data  in   8  read data for reg_addr; must be valid 1 PCLK after reg_addr changes
//   busy         out  1  1 from address match until STOP/START/NACK-ends the transfer
// BEHAVIOUR
// - Reset: SDA_OE=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, busy=0, state IDLE, filters=1.
// - Inputs: 2-FF synchronizer, then filter (FILT_LEN stable cycles). Edges taken on filtered
//   lines only. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
// - Bits sampled on filtered SCL rise, MSB first. SDA_OE changes only in the cycle after a
//   filtered SCL fall (gives hold time), except release on START/STOP/reset.
// - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP.
// - START in any state (incl. repeated START) -> ADDR, bit counter=0, SDA_OE=0.
//   STOP in any state -> IDLE, SDA_OE=0, busy=0. Partial bytes are discarded, no write issued.
// - ADDR: 8 bits. byte[7:1]==SLAVE_ADDR -> ADDR_ACK, busy=1, SDA_OE=1 from the 8th-bit SCL
//   fall to the 9th-bit SCL fall. Mismatch -> WAIT_STOP, SDA_OE stays 0 (no ACK).
// - After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA with shift register loaded from reg_rd_data
//   at the 9th-bit SCL fall (pointer unchanged).
// - PTR: 8 bits -> reg_addr=byte, ACK (PTR_ACK) -> WDATA.
// - WDATA: 8 bits -> ACK; at the 9th-bit SCL rise pulse reg_wr_en for 1 cycle with
//   reg_addr=pointer, reg_wr_data=byte; next cycle pointer+1 (0xFF wraps to 0x00). Repeat.
// - RDATA: SDA_OE=~bit for bits 7..0, set at each SCL fall; SDA_OE=0 after the 8th-bit SCL
//   fall. RD_MACK samples SDA at 9th SCL rise: 0 (ACK) -> pointer+1 (wrap), reload from
//   reg_rd_data at next SCL fall, RDATA; 1 (NACK) -> WAIT_STOP, busy=0.
// - WAIT_STOP: SDA_OE=0, ignore bits until START or STOP.
// - START and STOP detection have priority over a same-cycle SCL edge.
// - Async reset mid-transfer releases SDA immediately; the pointer returns to 0.
// TESTING
// 1 START,0x78,0x05,0xA5,0x5A,STOP -> ACK on all 4 bytes; reg_wr_en pulses (0x05,0xA5) and
//   (0x06,0x5A); busy falls at STOP.
// 2 START,0x78,0x10,Sr,0x79, read 2 with ACK then NACK; model rd_data=~addr -> bytes 0xEF,
//   0xEE; SDA_OE=0 after NACK; reg_addr=0x11 at end.
// 3 START,0x7A,0x00,STOP -> no ACK (SDA_OE never 1), no reg_wr_en, busy stays 0.
// 4 START,0x78,0xFF,0x11,0x22,STOP -> writes (0xFF,0x11) and (0x00,0x22).
// 5 SCL high, 2-cycle SDA low glitch with FILT_LEN=3 -> no START detected, state stays IDLE.
// 6 STOP after 4 bits of a write byte -> no reg_wr_en, IDLE. PRESETN low mid-RDATA while
//   SDA_OE=1 -> SDA_OE=0 the same cycle.

Source files
------------

// File: rtl/i2c_slave_target.sv
// i2c_slave_target: filtered I2C target with 7-bit address match, register pointer and external register bank port
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         FILT_LEN   = 3
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);
    localparam int CW = $clog2(FILT_LEN) + 1;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
    } state_t;
    state_t r_state, w_state_nxt;
    logic [1:0] r_s1, r_s2, r_f, r_d;
    logic [CW-1:0] r_fc [2];
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt, r_ptr, w_ptr_nxt, r_wr_data, w_wr_data_nxt;
    logic r_oe, w_oe_nxt, r_busy, w_busy_nxt, r_wr_en, w_wr_en_nxt;
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    // Index 1 carries SCL, index 0 carries SDA; a filtered line moves only after FILT_LEN stable cycles
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_s1 <= '1;
            r_s2 <= '1;
            r_f  <= '1;
            r_d  <= '1;
            for (int i = 0; i < 2; i++) r_fc[i] <= '0;
        end else begin
            r_s1 <= {SCL_IN, SDA_IN};
            r_s2 <= r_s1;
            r_d  <= r_f;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_f[i]) r_fc[i] <= '0;
                else if (r_fc[i] == CW'(FILT_LEN - 1)) begin
                    r_f[i]  <= r_s2[i];
                    r_fc[i] <= '0;
                end else r_fc[i] <= r_fc[i] + 1'b1;
            end
        end
    end
    assign w_sda      = r_f[0];
    assign w_scl_rise = r_f[1] & ~r_d[1];
    assign w_scl_fall = ~r_f[1] & r_d[1];
    assign w_start    = r_f[1] & r_d[1] & r_d[0] & ~r_f[0];
    assign w_stop     = r_f[1] & r_d[1] & ~r_d[0] & r_f[0];
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_wr_data <= '0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_oe      <= w_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_en   <= w_wr_en_nxt;
        end
    end
    // Bits are taken on SCL rise; SDA drive and state handoffs happen on SCL fall
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_wr_en ? r_ptr + 8'd1 : r_ptr;
        w_wr_data_nxt = r_wr_data;
        w_oe_nxt      = r_oe;
        w_busy_nxt    = r_busy;
        w_wr_en_nxt   = 1'b0;
        if (w_start) begin
            w_state_nxt = ADDR;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_scl_rise) begin
            case (r_state)
                ADDR, PTR, WDATA: begin
                    w_shift_nxt = {r_shift[6:0], w_sda};
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
                RDATA: w_cnt_nxt = r_cnt + 4'd1;
                WDATA_ACK: begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = r_shift;
                end
                RD_MACK: begin
                    if (w_sda) begin
                        w_state_nxt = WAIT_STOP;
                        w_busy_nxt  = 1'b0;
                    end else w_ptr_nxt = r_ptr + 8'd1;
                end
                default: ;
            endcase
        end else if (w_scl_fall) begin
            case (r_state)
                ADDR: if (r_cnt == 4'd8) begin
                    w_state_nxt = (r_shift[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                    w_oe_nxt    = r_shift[7:1] == SLAVE_ADDR;
                    w_busy_nxt  = r_shift[7:1] == SLAVE_ADDR;
                end
                ADDR_ACK: begin
                    w_state_nxt = r_shift[0] ? RDATA : PTR;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift[0] ? reg_rd_data : r_shift;
                    w_oe_nxt    = r_shift[0] & ~reg_rd_data[7];
                end
                PTR: if (r_cnt == 4'd8) begin
                    w_state_nxt = PTR_ACK;
                    w_ptr_nxt   = r_shift;
                    w_oe_nxt    = 1'b1;
                end
                WDATA: if (r_cnt == 4'd8) begin
                    w_state_nxt = WDATA_ACK;
                    w_oe_nxt    = 1'b1;
                end
                PTR_ACK, WDATA_ACK: begin
                    w_state_nxt = WDATA;
                    w_cnt_nxt   = '0;
                    w_oe_nxt    = 1'b0;
                end
                RDATA: begin
                    w_state_nxt = (r_cnt == 4'd8) ? RD_MACK : RDATA;
                    w_oe_nxt    = (r_cnt == 4'd8) ? 1'b0 : ~r_shift[3'd7 - r_cnt[2:0]];
                end
                RD_MACK: begin
                    w_state_nxt = RDATA;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = reg_rd_data;
                    w_oe_nxt    = ~reg_rd_data[7];
                end
                default: w_oe_nxt = 1'b0;
            endcase
        end
    end
    assign SDA_OE      = r_oe;
    assign reg_wr_en   = r_wr_en;
    assign reg_addr    = r_ptr;
    assign reg_wr_data = r_wr_data;
    assign busy        = r_busy;
endmodule

// File: tb/tb_i2c_slave_target.sv
// tb_i2c_slave_target: directed bus-level bench acting as I2C master and register bank
module tb_i2c_slave_target;
    logic PCLK = 1'b0;
    logic PRESETN = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic SDA_IN, SDA_OE, reg_wr_en, busy;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
    int n_checks = 0;
    int n_fail = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;
    logic [7:0] wa [$];
    logic [7:0] wd [$];

    assign SDA_IN = sda_m & ~SDA_OE;
    assign reg_rd_data = ~reg_addr;

    i2c_slave_target dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .SCL_IN(scl), .SDA_IN(SDA_IN), .SDA_OE(SDA_OE),
        .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (SDA_OE) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (reg_wr_en) begin
            wa.push_back(reg_addr);
            wd.push_back(reg_wr_data);
        end
    end

    task automatic q();
        repeat (20) @(negedge PCLK);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q();
        scl = 1'b1; q();
        sda_m = 1'b0; q();
        scl = 1'b0; q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q();
        scl = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; q();
        scl = 1'b1; q(); q();
        scl = 1'b0; q();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; q();
        scl = 1'b1; q();
        b = SDA_IN; q();
        scl = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(x);
        ack = ~x;
    endtask

    task automatic rbyte(output logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) rbit(v[i]);
        wbit(~ack);
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (SDA_OE !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", SDA_OE); end
        if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", reg_wr_en); end
        if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %02h want 00", reg_addr); end
        if (reg_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %02h want 00", reg_wr_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_write();
        logic a;
        logic [7:0] v [4] = '{8'h78, 8'h05, 8'hA5, 8'h5A};
        wa.delete(); wd.delete();
        bus_start();
        for (int i = 0; i < 4; i++) begin
            wbyte(v[i], a);
            n_checks++;
            if (a !== 1'b1) begin n_fail++; $display("FAIL write_ack%0d got %b want 1", i, a); end
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy got %b want 1", busy); end
        bus_stop(); q();
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop got %b want 0", busy); end
        if (wa.size() != 2) begin n_fail++; $display("FAIL write_count got %0d want 2", wa.size()); end
        else begin
            n_checks += 2;
            if ({wa[0], wd[0]} !== 16'h05A5) begin n_fail++; $display("FAIL write_0 got %02h/%02h want 05/A5", wa[0], wd[0]); end
            if ({wa[1], wd[1]} !== 16'h065A) begin n_fail++; $display("FAIL write_1 got %02h/%02h want 06/5A", wa[1], wd[1]); end
        end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] b0, b1;
        wa.delete(); wd.delete();
        bus_start();
        wbyte(8'h78, a);
        wbyte(8'h10, a);
        bus_start();
        wbyte(8'h79, a);
        n_checks++;
        if (a !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack got %b want 1", a); end
        rbyte(b0, 1'b1);
        rbyte(b1, 1'b0);
        q();
        n_checks += 4;
        if (b0 !== 8'hEF) begin n_fail++; $display("FAIL read_byte0 got %02h want EF", b0); end
        if (b1 !== 8'hEE) begin n_fail++; $display("FAIL read_byte1 got %02h want EE", b1); end
        if (SDA_OE !== 1'b0) begin n_fail++; $display("FAIL read_oe_nack got %b want 0", SDA_OE); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_nack got %b want 0", busy); end
        bus_stop(); q();
        n_checks += 2;
        if (reg_addr !== 8'h11) begin n_fail++; $display("FAIL read_ptr got %02h want 11", reg_addr); end
        if (wa.size() != 0) begin n_fail++; $display("FAIL read_no_write got %0d want 0", wa.size()); end
    endtask

    task automatic test_nomatch();
        logic a;
        wa.delete(); wd.delete();
        oe_seen = 1'b0; busy_seen = 1'b0;
        bus_start();
        wbyte(8'h7A, a);
        n_checks++;
        if (a !== 1'b0) begin n_fail++; $display("FAIL nomatch_ack got %b want 0", a); end
        wbyte(8'h00, a);
        bus_stop(); q();
        n_checks += 3;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL nomatch_oe got %b want 0", oe_seen); end
        if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL nomatch_busy got %b want 0", busy_seen); end
        if (wa.size() != 0) begin n_fail++; $display("FAIL nomatch_write got %0d want 0", wa.size()); end
    endtask

    task automatic test_wrap();
        logic a;
        wa.delete(); wd.delete();
        bus_start();
        wbyte(8'h78, a);
        wbyte(8'hFF, a);
        wbyte(8'h11, a);
        wbyte(8'h22, a);
        bus_stop(); q();
        n_checks += 2;
        if (reg_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr got %02h want 01", reg_addr); end
        if (wa.size() != 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", wa.size()); end
        else begin
            n_checks += 2;
            if ({wa[0], wd[0]} !== 16'hFF11) begin n_fail++; $display("FAIL wrap_0 got %02h/%02h want FF/11", wa[0], wd[0]); end
            if ({wa[1], wd[1]} !== 16'h0022) begin n_fail++; $display("FAIL wrap_1 got %02h/%02h want 00/22", wa[1], wd[1]); end
        end
    endtask

    task automatic test_glitch();
        logic a, x;
        oe_seen = 1'b0;
        @(negedge PCLK) sda_m = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK) sda_m = 1'b1;
        q();
        scl = 1'b0; q();
        wbyte(8'h78, a);
        scl = 1'b1; q();
        n_checks += 2;
        if (a !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_ack got %b want 0", a); end
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_oe got %b want 0", oe_seen); end
        wa.delete(); wd.delete();
        bus_start();
        wbyte(8'h78, a);
        wbyte(8'h40, a);
        for (int i = 0; i < 7; i++) wbit(1'b1);
        sda_m = 1'b1; q();
        scl = 1'b1; q();
        @(negedge PCLK) sda_m = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK) sda_m = 1'b1;
        q();
        scl = 1'b0; q();
        rbit(x);
        bus_stop(); q();
        n_checks += 2;
        if (x !== 1'b0) begin n_fail++; $display("FAIL glitch_data_ack got %b want 0", x); end
        if (wa.size() != 1) begin n_fail++; $display("FAIL glitch_write_count got %0d want 1", wa.size()); end
        else begin
            n_checks++;
            if ({wa[0], wd[0]} !== 16'h40FF) begin n_fail++; $display("FAIL glitch_write got %02h/%02h want 40/FF", wa[0], wd[0]); end
        end
    endtask

    task automatic test_abort_reset();
        logic a, x;
        wa.delete(); wd.delete();
        bus_start();
        wbyte(8'h78, a);
        wbyte(8'h30, a);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        bus_stop(); q();
        n_checks += 2;
        if (wa.size() != 0) begin n_fail++; $display("FAIL abort_write got %0d want 0", wa.size()); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        bus_start();
        wbyte(8'h78, a);
        wbyte(8'h30, a);
        bus_start();
        wbyte(8'h79, a);
        rbit(x);
        rbit(x);
        n_checks++;
        if (SDA_OE !== 1'b1) begin n_fail++; $display("FAIL rst_pre_oe got %b want 1", SDA_OE); end
        @(negedge PCLK) PRESETN = 1'b0;
        #1;
        n_checks += 3;
        if (SDA_OE !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", SDA_OE); end
        if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL rst_ptr got %02h want 00", reg_addr); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        @(negedge PCLK) PRESETN = 1'b1;
        sda_m = 1'b1; scl = 1'b1;
        q();
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        test_reset();
        PRESETN = 1'b1;
        q();
        test_write();
        test_read();
        test_nomatch();
        test_wrap();
        test_glitch();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
